// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, flag bit positions, exec FSM states.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_SEL_W  = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {ST_IDLE, ST_MUL} exec_state_t;

  // Single-cycle ops that produce a register write-back.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_SHR) || (op == OP_MOV);
  endfunction

  // Single-cycle ops that update the status flags (MUL is handled on completion).
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op <= OP_MOV) && (op != OP_MUL);
  endfunction
endpackage

// File: rtl/cpu_mul_iter.sv
// Iterative unsigned shift-add multiplier; one multiplier bit per cycle.
// Bit 0 is folded into the start cycle so done pulses DATA_W cycles after start.
module cpu_mul_iter
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;

  // Load on start, then accumulate the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
      mcand  <= {{DATA_W{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CW'(DATA_W - 1);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      done   <= (cnt == CW'(1));
    end else begin
      done   <= 1'b0;
    end
  end

  assign product = acc;
endmodule

// File: rtl/cpu_exec_unit.sv
// Execute stage: combinational ALU, iterative MUL, registered write-back pulse and flags.
module cpu_exec_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int SEL_W  = CPU_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [SEL_W-1:0]  op_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [SEL_W-1:0]  wb_sel,
  output logic              wb_we,
  output logic [3:0]        flags,
  output logic              busy
);
  exec_state_t state, state_nxt;

  logic                accept, mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic [SEL_W-1:0]    mul_dst;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v;
  logic [DATA_W:0]     sum, diff, shl_full, shr_full;
  logic [3:0]          alu_flags, mul_flags;
  logic [3:0]          amt;

  assign accept    = op_valid && op_ready;
  assign mul_start = accept && (op_code == OP_MUL);
  assign amt       = op_b[3:0];
  assign sum       = {1'b0, op_a} + {1'b0, op_b};
  assign diff      = {1'b0, op_a} - {1'b0, op_b};
  // Extra bit on the shifted-out side captures the last bit lost; zero for amount 0.
  assign shl_full  = {1'b0, op_a} << amt;
  assign shr_full  = {op_a, 1'b0} >> amt;

  cpu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // ALU result and carry/overflow for the single-cycle opcodes.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = diff[DATA_W];
        alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = shl_full[DATA_W-1:0];
        alu_c   = shl_full[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_full[DATA_W:1];
        alu_c   = shr_full[0];
      end
      OP_MOV: alu_res = op_a;
      default: ;
    endcase
  end

  assign alu_flags = {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
  assign mul_flags = {mul_prod[DATA_W-1:0] == '0, mul_prod[DATA_W-1],
                      mul_prod[2*DATA_W-1:DATA_W] != '0, mul_prod[2*DATA_W-1:DATA_W] != '0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (mul_start) state_nxt = ST_MUL;
      end
      ST_MUL: begin
        busy = 1'b1;
        if (mul_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write-back pulse, held data/select, and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_data <= '0;
      wb_sel  <= '0;
      flags   <= '0;
      mul_dst <= '0;
    end else begin
      wb_we <= 1'b0;
      if (mul_start) mul_dst <= op_dst;
      if (accept && op_writes(op_code)) begin
        wb_we   <= 1'b1;
        wb_data <= alu_res;
        wb_sel  <= op_dst;
      end
      if (accept && op_sets_flags(op_code)) flags <= alu_flags;
      if (state == ST_MUL && mul_done) begin
        wb_we   <= 1'b1;
        wb_data <= mul_prod[DATA_W-1:0];
        wb_sel  <= mul_dst;
        flags   <= mul_flags;
      end
    end
  end
endmodule

// File: tb/tb_cpu_exec_unit.sv
// Scoreboard bench: stimulus pushes expected write-backs, a monitor pops on each wb_we pulse.
module tb_cpu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_dst;
  logic [15:0] wb_data;
  logic [2:0]  wb_sel;
  logic        wb_we;
  logic [3:0]  flags;
  logic        busy;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
    logic [3:0]  f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cpu_exec_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
    .wb_data(wb_data), .wb_sel(wb_sel), .wb_we(wb_we), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got data 0x%0h sel %0d, none expected", wb_data, wb_sel);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_data", 32'(wb_data), 32'(e.d));
        chk("wb_sel",  32'(wb_sel),  32'(e.s));
        chk("wb_flags", 32'(flags),  32'(e.f));
      end
    end
  end

  // Present one op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] dst);
    int n;
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b; op_dst = dst;
    n = 0;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: op_ready stayed 0, op %0d", op);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [15:0] d, input logic [2:0] s, input logic [3:0] f);
    exp_t e;
    e.d = d; e.s = s; e.f = f;
    q.push_back(e);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [2:0]  dst;
    logic [15:0] d;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lows;
    int early;
    // {Z,N,C,V} expected flags
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 3'd3, 16'h8000, 4'b0101}; // ADD overflow
    vecs[1]  = '{4'd1,  16'h0001, 16'h0002, 3'd1, 16'hFFFF, 4'b0110}; // SUB borrow
    vecs[2]  = '{4'd6,  16'h8001, 16'h0001, 3'd2, 16'h0002, 4'b0010}; // SHL carry out
    vecs[3]  = '{4'd7,  16'h0001, 16'h0000, 3'd4, 16'h0001, 4'b0000}; // SHR by 0
    vecs[4]  = '{4'd2,  16'hF0F0, 16'h0FF0, 3'd5, 16'h00F0, 4'b0000}; // AND
    vecs[5]  = '{4'd3,  16'hF000, 16'h000F, 3'd6, 16'hF00F, 4'b0100}; // OR
    vecs[6]  = '{4'd4,  16'hAAAA, 16'hAAAA, 3'd0, 16'h0000, 4'b1000}; // XOR
    vecs[7]  = '{4'd5,  16'h00FF, 16'h1234, 3'd7, 16'hFF00, 4'b0100}; // NOT
    vecs[8]  = '{4'd10, 16'h1234, 16'hFFFF, 3'd2, 16'h1234, 4'b0000}; // MOV
    vecs[9]  = '{4'd0,  16'hFFFF, 16'h0001, 3'd1, 16'h0000, 4'b1010}; // ADD carry, zero
    vecs[10] = '{4'd1,  16'h8000, 16'h0001, 3'd3, 16'h7FFF, 4'b0001}; // SUB overflow
    vecs[11] = '{4'd7,  16'h8003, 16'h0002, 3'd5, 16'h2000, 4'b0001}; // SHR carry? see below
    // SHR 0x8003 by 2: result 0x2000, last bit out = bit1 = 1 -> C=1 => flags 0010
    vecs[11].f = 4'b0010;

    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; op_dst = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_we",    32'(wb_we),    32'd0);
    chk("rst_data",  32'(wb_data),  32'd0);
    chk("rst_sel",   32'(wb_sel),   32'd0);
    chk("rst_flags", 32'(flags),    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD then unused opcode 12: no write-back, flags keep ADD values
    expect_wb(16'h8000, 3'd3, 4'b0101);
    send(4'd0, 16'h7FFF, 16'h0001, 3'd3);
    send(4'd12, 16'h1111, 16'h2222, 3'd4);
    @(negedge clk);
    chk("op12_flags", 32'(flags), 32'h5);
    chk("op12_no_we", 32'(wb_we), 32'd0);

    // SUB then CMP back-to-back
    expect_wb(16'hFFFF, 3'd1, 4'b0110);
    send(4'd1, 16'h0001, 16'h0002, 3'd1);
    send(4'd9, 16'h0005, 16'h0005, 3'd6);
    @(negedge clk);
    chk("cmp_flags", 32'(flags), 32'h8);
    chk("cmp_no_we", 32'(wb_we), 32'd0);

    // Back-to-back directed table
    for (int i = 0; i < 12; i++) begin
      expect_wb(vecs[i].d, vecs[i].dst, vecs[i].f);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst);
    end
    repeat (3) @(negedge clk);

    // MUL 0x0100*0x0100: 16 stalled cycles, junk op held meanwhile is ignored
    expect_wb(16'h0000, 3'd7, 4'b1011);
    send(4'd8, 16'h0100, 16'h0100, 3'd7);
    chk("mul_busy", 32'(busy), 32'd1);
    op_valid = 1'b1; op_code = 4'd0; op_a = 16'h1111; op_b = 16'h2222; op_dst = 3'd2;
    lows = 0;
    early = 0;
    repeat (16) begin
      @(negedge clk);
      if (!op_ready) lows++;
      if (wb_we) early++;
    end
    op_valid = 1'b0;
    chk("mul_stall_cycles", 32'(lows), 32'd16);
    chk("mul_early_wb", 32'(early), 32'd0);
    @(negedge clk);
    chk("mul_wb_at_n17", 32'(wb_we), 32'd1);
    chk("mul_ready_back", 32'(op_ready), 32'd1);
    @(negedge clk);
    chk("mul_single_pulse", 32'(wb_we), 32'd0);

    // Reset in the middle of a MUL: nothing is written back
    send(4'd8, 16'h0003, 16'h0005, 3'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(op_ready), 32'd1);
    chk("midrst_busy",  32'(busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_flags", 32'(flags), 32'd0);
    repeat (25) @(negedge clk);
    chk("midrst_ready_after", 32'(op_ready), 32'd1);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
